// File: rtl/risc8_regs_pkg.sv
// risc8_regs_pkg: shared definitions for the risc8 multi-port register file.
//   - REG_COUNT_DEFAULT : default number of 8-bit registers
//   - SRC_*             : per-output-byte source encodings (RAM lane or bypass lane)
//   - clr_state_e       : clear sequencer state encoding
//   - pick_byte()       : output byte mux shared by every read port
// Optional feature macro: RISC8_REGS_BYPASS_EN (same-edge read-after-write bypass).
package risc8_regs_pkg;

   localparam int unsigned REG_COUNT_DEFAULT = 32;

   localparam logic [1:0] SRC_RAM_LO = 2'd0;
   localparam logic [1:0] SRC_RAM_HI = 2'd1;
   localparam logic [1:0] SRC_BYP_LO = 2'd2;
   localparam logic [1:0] SRC_BYP_HI = 2'd3;

   typedef enum logic {
      StClear = 1'b0,
      StReady = 1'b1
   } clr_state_e;

   function automatic logic [7:0] pick_byte(logic [1:0] src, logic [15:0] ram, logic [15:0] byp);
      logic [7:0] b;
      unique case (src)
         SRC_RAM_LO: b = ram[7:0];
         SRC_RAM_HI: b = ram[15:8];
         SRC_BYP_LO: b = byp[7:0];
         SRC_BYP_HI: b = byp[15:8];
         default:    b = ram[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/risc8_regs_rdport.sv
// risc8_regs_rdport: one read port of the register file. Holds a private copy of the
// word-organised RAM (written by the shared write port), the registered read word and
// the per-byte source selects, and drives the port's {hi, lo} result.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   ready                 clear sequence finished; output forced to 0 while low
//   clr_en                current RAM write is a clear write
//   ram_we_lo/hi          byte-lane write enables of the shared write port
//   ram_idx, ram_wdata    word index and data of the shared write port
//   byp_we_lo/hi, byp_idx lanes/word of a core (non-clear) write this edge
//   byp_data              shared bypass latch
//   rd_addr, rd_data      register address in, {hi, lo} result out
// Optional feature macro: RISC8_REGS_BYPASS_EN.
module risc8_regs_rdport
   import risc8_regs_pkg::*;
#(
   parameter int unsigned REG_COUNT = REG_COUNT_DEFAULT,
   localparam int unsigned AW = $clog2(REG_COUNT),
   localparam int unsigned WW = AW - 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ready,
   input  logic          clr_en,
   input  logic          ram_we_lo,
   input  logic          ram_we_hi,
   input  logic [WW-1:0] ram_idx,
   input  logic [15:0]   ram_wdata,
   input  logic          byp_we_lo,
   input  logic          byp_we_hi,
   input  logic [WW-1:0] byp_idx,
   input  logic [15:0]   byp_data,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data
);

   logic [15:0]   mem [REG_COUNT/2];
   logic [WW-1:0] rd_idx;
   logic [15:0]   rd_word_d, rd_word_q;
   logic [1:0]    src_lo_d, src_lo_q;
   logic [1:0]    src_hi_d, src_hi_q;

   assign rd_idx = rd_addr[AW-1:1];

   always_ff @(posedge clk) begin
      if (ram_we_lo) mem[ram_idx][7:0]  <= ram_wdata[7:0];
      if (ram_we_hi) mem[ram_idx][15:8] <= ram_wdata[15:8];
   end

   // A word being cleared on this edge reads back as zero, so the read issued on the
   // final clear edge cannot expose pre-reset contents.
   always_comb begin
      rd_word_d = mem[rd_idx];
      if (clr_en && (ram_idx == rd_idx)) rd_word_d = '0;
   end

`ifdef RISC8_REGS_BYPASS_EN
   logic hit;
   assign hit = (byp_idx == rd_idx);

   // lo byte is R[a]: lane 1 of the pair when a is odd, lane 0 when even.
   // hi byte is always lane 1 of the pair.
   always_comb begin
      src_lo_d = rd_addr[0] ? SRC_RAM_HI : SRC_RAM_LO;
      src_hi_d = SRC_RAM_HI;
      if (hit && byp_we_hi) src_hi_d = SRC_BYP_HI;
      if (rd_addr[0]) begin
         if (hit && byp_we_hi) src_lo_d = SRC_BYP_HI;
      end else begin
         if (hit && byp_we_lo) src_lo_d = SRC_BYP_LO;
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^{byp_we_lo, byp_we_hi, byp_idx};

   always_comb begin
      src_lo_d = rd_addr[0] ? SRC_RAM_HI : SRC_RAM_LO;
      src_hi_d = SRC_RAM_HI;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_word_q <= '0;
         src_lo_q  <= SRC_RAM_LO;
         src_hi_q  <= SRC_RAM_LO;
      end else begin
         rd_word_q <= rd_word_d;
         src_lo_q  <= src_lo_d;
         src_hi_q  <= src_hi_d;
      end
   end

   always_comb begin
      rd_data = '0;
      if (ready) begin
         rd_data = {pick_byte(src_hi_q, rd_word_q, byp_data),
                    pick_byte(src_lo_q, rd_word_q, byp_data)};
      end
   end

endmodule

// File: rtl/risc8_regs_mp.sv
// risc8_regs_mp: multi-read-port register file for the risc8 core. 8-bit registers are
// stored as 16-bit word pairs; the RAM is replicated per read port and all copies share
// one byte/word write port. A clear sequencer zeroes every word after reset.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   ready        high once the clear sequence has finished
//   rd_addr      READ_PORTS*AW, port k at [k*AW +: AW]
//   rd_data      READ_PORTS*16, port k at [k*16 +: 16], {hi, lo}
//   wr_en        write strobe (ignored while ready is low)
//   wr_word      1 = 16-bit pair write, 0 = byte write
//   wr_addr      write register address
//   wr_data      write data, byte writes use [7:0]
// Optional feature macro: RISC8_REGS_BYPASS_EN (same-edge read-after-write bypass).
module risc8_regs_mp
   import risc8_regs_pkg::*;
#(
   parameter int unsigned REG_COUNT  = REG_COUNT_DEFAULT,
   parameter int unsigned READ_PORTS = 2,
   localparam int unsigned AW = $clog2(REG_COUNT),
   localparam int unsigned WW = AW - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     ready,
   input  logic [READ_PORTS*AW-1:0] rd_addr,
   output logic [READ_PORTS*16-1:0] rd_data,
   input  logic                     wr_en,
   input  logic                     wr_word,
   input  logic [AW-1:0]            wr_addr,
   input  logic [15:0]              wr_data
);

   localparam logic [WW-1:0] LastWord = WW'(REG_COUNT/2 - 1);

   clr_state_e    state_d, state_q;
   logic [WW-1:0] cnt_d, cnt_q;

   logic          clr_en, wr_ok;
   logic          ram_we_lo, ram_we_hi;
   logic [WW-1:0] ram_idx;
   logic [15:0]   ram_wdata;
   logic          byp_we_lo, byp_we_hi;
   logic [15:0]   byp_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StClear: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastWord) state_d = StReady;
         end
         StReady: state_d = StReady;
         default: state_d = StClear;
      endcase
   end

   assign ready  = (state_q == StReady);
   assign clr_en = (state_q == StClear) && reset;
   assign wr_ok  = (state_q == StReady) && reset && wr_en;

   // Byte writes replicate the byte into both lanes so the bypass latch can serve either.
   always_comb begin
      ram_we_lo = 1'b0;
      ram_we_hi = 1'b0;
      ram_idx   = wr_addr[AW-1:1];
      ram_wdata = wr_word ? wr_data : {wr_data[7:0], wr_data[7:0]};
      if (clr_en) begin
         ram_we_lo = 1'b1;
         ram_we_hi = 1'b1;
         ram_idx   = cnt_q;
         ram_wdata = '0;
      end else if (wr_ok) begin
         ram_we_lo = wr_word | ~wr_addr[0];
         ram_we_hi = wr_word | wr_addr[0];
      end
   end

   assign byp_we_lo = wr_ok & ram_we_lo;
   assign byp_we_hi = wr_ok & ram_we_hi;

`ifdef RISC8_REGS_BYPASS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         byp_q <= '0;
      end else if (wr_ok) begin
         byp_q <= ram_wdata;
      end
   end
`else
   assign byp_q = '0;
`endif

   for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
      risc8_regs_rdport #(
         .REG_COUNT(REG_COUNT)
      ) u_rdport (
         .clk       (clk),
         .reset     (reset),
         .ready     (ready),
         .clr_en    (clr_en),
         .ram_we_lo (ram_we_lo),
         .ram_we_hi (ram_we_hi),
         .ram_idx   (ram_idx),
         .ram_wdata (ram_wdata),
         .byp_we_lo (byp_we_lo),
         .byp_we_hi (byp_we_hi),
         .byp_idx   (ram_idx),
         .byp_data  (byp_q),
         .rd_addr   (rd_addr[k*AW +: AW]),
         .rd_data   (rd_data[k*16 +: 16])
      );
   end

endmodule

// File: tb/tb_risc8_regs_mp.sv
// Self-checking bench for risc8_regs_mp (REG_COUNT=32, READ_PORTS=3).
// A register-level model (array of 32 bytes plus a clear-progress counter) predicts
// every port result each cycle; directed vectors add literal expectations.
module tb_risc8_regs_mp;

   localparam int RC = 32;
   localparam int RP = 3;
   localparam int AW = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             ready;
   logic [RP*AW-1:0] rd_addr;
   logic [RP*16-1:0] rd_data;
   logic             wr_en;
   logic             wr_word;
   logic [AW-1:0]    wr_addr;
   logic [15:0]      wr_data;

   int errors = 0;
   int checks = 0;

   risc8_regs_mp #(
      .REG_COUNT (RC),
      .READ_PORTS(RP)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .ready  (ready),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .wr_en  (wr_en),
      .wr_word(wr_word),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0]  r_m [RC];
   logic [15:0] exp_q [RP];
   logic        ready_m = 1'b0;
   int          clr_edges = 0;
   logic        started = 1'b0;

   function automatic logic [7:0] model_byte(int r, logic wrote);
`ifdef RISC8_REGS_BYPASS_EN
      if (wrote) begin
         if (wr_word && ((r / 2) == (int'(wr_addr) / 2)))
            return (r % 2 == 1) ? wr_data[15:8] : wr_data[7:0];
         if (!wr_word && (r == int'(wr_addr)))
            return wr_data[7:0];
      end
`endif
      return r_m[r];
   endfunction

   always @(posedge clk) begin : model
      int   ce, a, hr;
      logic rdy_before, rdy_after, wrote;
      rdy_before = reset && (clr_edges >= RC/2);
      ce = !reset ? 0 : ((clr_edges < RC/2) ? clr_edges + 1 : clr_edges);
      rdy_after = reset && (ce >= RC/2);
      wrote = rdy_before && wr_en;
      for (int p = 0; p < RP; p++) begin
         a  = int'(rd_addr[p*AW +: AW]);
         hr = a | 1;
         exp_q[p] <= rdy_after ? {model_byte(hr, wrote), model_byte(a, wrote)} : 16'h0000;
      end
      if (!reset) begin
         for (int i = 0; i < RC; i++) r_m[i] <= 8'h00;
      end else if (wrote) begin
         if (wr_word) begin
            r_m[int'(wr_addr) & ~1] <= wr_data[7:0];
            r_m[int'(wr_addr) | 1]  <= wr_data[15:8];
         end else begin
            r_m[int'(wr_addr)] <= wr_data[7:0];
         end
      end
      clr_edges <= ce;
      ready_m   <= rdy_after;
      started   <= 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (ready !== ready_m) begin
            errors++;
            $display("FAIL ready_model t=%0t: got %b expected %b", $time, ready, ready_m);
         end
         for (int p = 0; p < RP; p++) begin
            checks++;
            if (rd_data[p*16 +: 16] !== exp_q[p]) begin
               errors++;
               $display("FAIL port%0d_model t=%0t: got %h expected %h",
                        p, $time, rd_data[p*16 +: 16], exp_q[p]);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   function automatic logic [15:0] port(input int p);
      return rd_data[p*16 +: 16];
   endfunction

   task automatic write(input logic word, input int addr, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_word = word;
      wr_addr = AW'(addr);
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Counts edges from the current point until ready is seen high (bounded).
   task automatic count_clear(input string name, input int already);
      int n = already;
      do begin
         tick();
         n++;
      end while (!ready && n < 64);
      chk(name, 16'(n), 16'd16);
   endtask

   initial begin
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_word = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {15'd0, ready}, 16'h0000);
      chk("reset_rd0", port(0), 16'h0000);

      // Clear sequence and full sweep.
      reset = 1'b1;
      count_clear("clear_cycles", 0);
      for (int a = 0; a < RC; a += RP) begin
         for (int p = 0; p < RP; p++) set_rd(p, (a + p) % RC);
         tick();
         for (int p = 0; p < RP; p++) chk("cleared_read", port(p), 16'h0000);
      end

      // Word write.
      write(1'b1, 4, 16'hBEEF);
      set_rd(0, 4);
      set_rd(1, 5);
      tick();
      chk("word_rd4", port(0), 16'hBEEF);
      chk("word_rd5", port(1), 16'hBEBE);

      // Byte writes.
      write(1'b0, 6, 16'h0012);
      write(1'b0, 7, 16'h0034);
      set_rd(0, 6);
      tick();
      chk("byte_rd6", port(0), 16'h3412);
      write(1'b0, 7, 16'hAA56);
      tick();
      chk("byte_rd6_again", port(0), 16'h5612);

      // Top-of-range pair.
      write(1'b1, 31, 16'h9ABC);
      set_rd(0, 30);
      set_rd(1, 31);
      set_rd(2, 0);
      tick();
      chk("top_rd30", port(0), 16'h9ABC);
      chk("top_rd31", port(1), 16'h9A9A);

      // Same-edge read-after-write.
      set_rd(0, 8);
      set_rd(1, 9);
      set_rd(2, 8);
      write(1'b1, 8, 16'hA55A);
`ifdef RISC8_REGS_BYPASS_EN
      chk("byp_p0", port(0), 16'hA55A);
      chk("byp_p1", port(1), 16'hA5A5);
      chk("byp_p2", port(2), 16'hA55A);
`else
      chk("nobyp_p0", port(0), 16'h0000);
      chk("nobyp_p1", port(1), 16'h0000);
      chk("nobyp_p2", port(2), 16'h0000);
`endif
      tick();
      chk("after_p0", port(0), 16'hA55A);
      chk("after_p1", port(1), 16'hA5A5);
      write(1'b0, 9, 16'h0077);
`ifdef RISC8_REGS_BYPASS_EN
      chk("byp_byte_p0", port(0), 16'h775A);
      chk("byp_byte_p1", port(1), 16'h7777);
`else
      chk("nobyp_byte_p0", port(0), 16'hA55A);
      chk("nobyp_byte_p1", port(1), 16'hA5A5);
`endif
      tick();
      chk("after_byte_p0", port(0), 16'h775A);

      // Writes ignored during clear (write on clear cycle 3).
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      tick();
      chk("clear_not_ready", {15'd0, ready}, 16'h0000);
      wr_en   = 1'b1;
      wr_word = 1'b1;
      wr_addr = '0;
      wr_data = 16'hFFFF;
      tick();
      wr_en = 1'b0;
      count_clear("clear_cycles_w", 3);
      set_rd(0, 0);
      set_rd(1, 1);
      set_rd(2, 8);
      tick();
      chk("ignored_wr_rd0", port(0), 16'h0000);
      chk("ignored_wr_rd1", port(1), 16'h0000);
      chk("recleared_rd8", port(2), 16'h0000);

      // Reset mid-clear restarts the count.
      write(1'b1, 2, 16'h1357);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (10) tick();
      chk("mid_not_ready", {15'd0, ready}, 16'h0000);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      count_clear("mid_clear_cycles", 0);
      set_rd(0, 2);
      tick();
      chk("mid_rd2", port(0), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/risc8_regs_mp.md
# risc8_regs_mp

Parametrised multi-read-port register file for the risc8 core: byte-addressed 8-bit registers stored as 16-bit word pairs in block RAM. The RAM is replicated once per read port, and all copies share a single byte/word write port. Same-cycle read-after-write bypass makes a write visible to a read issued on the same edge. A post-reset clear sequencer zeroes every register before the core may issue accesses. The block sits between decode (addresses) and the ALU/LSU (operands, writeback).

## Interface
Parameters:
- REG_COUNT, 32, number of 8-bit registers; power of two, 4..256. Local AW = log2(REG_COUNT).
- READ_PORTS, 2, number of independent read ports, 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- ready  out  1  high once the clear sequence has finished
- rd_addr  in  READ_PORTS*AW  read address per port; port k uses slice [k*AW +: AW]
- rd_data  out  READ_PORTS*16  per-port result {hi, lo}; port k uses slice [k*16 +: 16]
- wr_en  in  1  write strobe
- wr_word  in  1  1 = 16-bit pair write, 0 = byte write
- wr_addr  in  AW  write register address
- wr_data  in  16  write data; byte writes use [7:0]

## Operation
- Read result for address a:
  - lo = R[a]
  - hi = R[{a[AW-1:1],1}]
  - Even a returns the pair {R[a+1], R[a]}. Odd a returns {R[a], R[a]}.
- Word write: wr_addr[0] is ignored. R[{w,0}] <= wr_data[7:0] and R[{w,1}] <= wr_data[15:8].
- Byte write: R[wr_addr] <= wr_data[7:0]. The other byte of the pair is untouched.
- Bypass: for a write and a read sampled on the same edge, each output byte whose register was written returns the new value from the bypass latch. Unwritten bytes come from RAM.
- Clear FSM: CLEAR -> READY.
  - reset=0: the FSM enters CLEAR and the word counter is set to 0.
  - CLEAR: each cycle, word[counter] <= 0 in every copy, then counter++. When counter reaches REG_COUNT/2-1, the next state is READY.
  - READY: holds until the next reset.
- While ready=0:
  - wr_en is ignored.
  - rd_data is forced to 0.
- Address arithmetic is modulo REG_COUNT; there are no out-of-range accesses.

## Timing
- Reset values: ready=0, rd_data=0, and all bypass select and latch state is 0.
- Clear duration: ready rises REG_COUNT/2 cycles after the first edge with reset=1. For REG_COUNT=32 that is 16 cycles.
- Read latency is 1: an address sampled at edge n drives rd_data after edge n. rd_data holds until edge n+1.
- Write at edge n:
  - It is committed to RAM at edge n.
  - A read sampled at edge n sees it via bypass.
  - A read sampled at edge n+1 or later sees it from RAM.
- Simultaneous events:
  - All ports reading the written register see identical data.
  - Multiple ports reading the same address see identical data.
- Reset mid-clear restarts the counter at 0.
- Reset during READY re-runs the full clear.

## Configuration
- RISC8_REGS_BYPASS_EN defined: same-edge read-after-write returns the new data, as described above.
- Undefined: there is no bypass latch or select logic. A read sampled on the same edge as a write to that register returns the pre-write value. Latency and every other behaviour are unchanged.

## Structure
- The shared package/header risc8_regs_pkg holds:
  - the byte-source encodings SRC_RAM_LO=0, SRC_RAM_HI=1, SRC_BYP_LO=2, SRC_BYP_HI=3
  - the clear FSM state encoding
  - the default REG_COUNT
- Sub-module risc8_regs_rdport: one RAM copy, its registered read word, the per-byte source selects, and the output mux. It is instantiated READ_PORTS times by a generate loop.
- The top level owns the clear FSM, the write decode and the shared bypass latch.

## Test plan
- Reset then clear: hold reset=0 for 3 cycles, release, and read all addresses once ready=1. ready must rise exactly 16 cycles after release, and every rd_data must be 0x0000.
- Word write: write wr_word=1, addr 4, 0xBEEF. Read port 0 at addr 4 returns 0xBEEF. Port 1 at addr 5 returns 0xBEBE.
- Byte write: write 0x12 to R6, then 0x34 to R7. A read at 6 returns 0x3412. A byte write of 0x56 to R7 then makes the read at 6 return 0x5612.
- Bypass:
  - Write word 0xA55A to addr 8 while ports 0/1/2 read 8/9/8 on the same edge. The results are 0xA55A, 0xA5A5 and 0xA55A.
  - With the macro undefined, all three return the prior value 0x0000.
- Writes ignored during clear: pulse reset, and attempt a write of 0xFFFF to addr 0 on cycle 3 of CLEAR. After ready, a read at 0 returns 0x0000.
- Mid-clear reset: assert reset=0 at clear cycle 10, then release. ready rises 16 cycles after the second release, not earlier.
